// File: rtl/uart_dbg_tx_fifo.sv
// uart_dbg_tx_fifo
// ----------------
// Elastic byte buffer between the button-triggered debug sequence generator
// and the UART debug transmit input. The generator bursts a byte every 16
// clocks, which is far faster than the UART can shift bytes out. This block
// stores the burst and replays it one byte at a time, paced by tx_busy.
//
// Optional build macro: UART_DBG_FIFO_STATS_EN
//   defined   -> drop_count / sent_count are live statistics counters
//   undefined -> both counters are tied to zero and no counter flops exist
//
// Ports:
//   clk         system clock (27 MHz in the top level)
//   resetb      asynchronous active-low reset
//   wr_en       one-cycle push strobe from the debug generator
//   wr_data     byte to push, sampled when wr_en=1
//   tx_busy     UART transmitter busy (high while a byte is shifting out)
//   tx_send     one-cycle send strobe to the UART
//   tx_data     byte to send, held from the strobe until the next pop
//   level       current occupancy, 0..DEPTH
//   full        level == DEPTH
//   empty       level == 0
//   overflow    sticky flag, a push was dropped
//   clr_ovf     synchronous clear of overflow (and drop_count)
//   drop_count  saturating dropped-byte counter (stats build only)
//   sent_count  wrapping bytes-sent counter (stats build only)

module uart_dbg_tx_fifo #(
  parameter  int DEPTH    = 32,
  parameter  int ACK_WAIT = 64,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          tx_busy,
  output logic          tx_send,
  output logic [7:0]    tx_data,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  input  logic          clr_ovf,
  output logic [7:0]    drop_count,
  output logic [15:0]   sent_count
);

  // The ACK counter must be able to hold ACK_WAIT itself, because it keeps
  // counting on the exit cycle before it is cleared in DRAIN.
  localparam int            CW       = $clog2(ACK_WAIT + 1);
  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    ACK,
    DRAIN
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] ack_cnt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_next;

  logic          push;
  logic          pop;
  logic          drop;

  // Full is taken from the registered level, so a push into a full FIFO is
  // dropped even when a pop happens in the same cycle.
  assign push = wr_en & ~full;
  assign drop = wr_en & full;

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Simultaneous push and pop leaves the occupancy unchanged.
  always_comb begin
    level_next = level;
    if (push && !pop) begin
      level_next = level + (AW+1)'(1);
    end else if (pop && !push) begin
      level_next = level - (AW+1)'(1);
    end
  end

  // full/empty are registered alongside level so all three change together.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      level <= level_next;
      full  <= (level_next == (AW+1)'(DEPTH));
      empty <= (level_next == '0);
    end
  end

  // A dropped push wins over a coincident clear.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  // tx_data only loads on a pop, which can only happen in IDLE, so it is
  // stable for the whole SEND/ACK/DRAIN handshake.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      tx_data <= 8'h00;
    end else if (pop) begin
      tx_data <= mem[rd_ptr];
    end
  end

  // State register plus the ACK timeout counter, which runs only in ACK.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state   <= IDLE;
      ack_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ACK) begin
        ack_cnt <= ack_cnt + CW'(1);
      end else begin
        ack_cnt <= '0;
      end
    end
  end

  // ACK falls through to DRAIN after ACK_WAIT cycles even without tx_busy,
  // so a missed strobe cannot lock the transmitter up.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop) state_next = SEND;
      SEND:    state_next = ACK;
      ACK:     if (tx_busy || (ack_cnt == ACK_LAST)) state_next = DRAIN;
      DRAIN:   if (!tx_busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: the strobe is the SEND state, pops start a handshake.
  always_comb begin
    tx_send = (state == SEND);
    pop     = (state == IDLE) & ~empty & ~tx_busy;
  end

`ifdef UART_DBG_FIFO_STATS_EN
  // drop_count saturates; a drop in the same cycle as clr_ovf still counts.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      drop_count <= 8'd0;
    end else if (drop) begin
      if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end else if (clr_ovf) begin
      drop_count <= 8'd0;
    end
  end

  // sent_count counts strobes and wraps at 16 bits.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sent_count <= 16'd0;
    end else if (state == SEND) begin
      sent_count <= sent_count + 16'd1;
    end
  end
`else
  assign drop_count = 8'd0;
  assign sent_count = 16'd0;
`endif

endmodule

// File: tb/tb_uart_dbg_tx_fifo.sv
// tb_uart_dbg_tx_fifo
// -------------------
// Directed bench for uart_dbg_tx_fifo. A queue-based model tracks the FIFO
// contents and the transmitter timing as "cycles since the last pop", and a
// negedge compare process checks every output against it each cycle. The
// directed sequence adds literal expectations for latency, byte order,
// peak level, overflow, the ACK timeout spacing and async reset.

module tb_uart_dbg_tx_fifo;

  localparam int DEPTH    = 32;
  localparam int ACK_WAIT = 64;
  localparam int AW       = $clog2(DEPTH);

  logic          clk     = 1'b0;
  logic          resetb  = 1'b1;
  logic          wr_en   = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          tx_busy = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          tx_send;
  logic [7:0]    tx_data;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          overflow;
  logic [7:0]    drop_count;
  logic [15:0]   sent_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int peak   = 0;

  // 0: tx_busy held low, 1: held high, 2: busy for 2900 cycles after a strobe
  int uart_mode = 0;

  logic [7:0] obs_data[$];
  int         obs_cyc[$];

  // Model state: queue contents, time since last pop, sticky flags, counters
  logic [7:0] mq[$];
  bit         m_idle  = 1'b1;
  int         m_t     = 0;
  bit         m_acked = 1'b0;
  logic [7:0] m_txd   = 8'h00;
  bit         m_ovf   = 1'b0;
  int         m_drop  = 0;
  int         m_sent  = 0;

  uart_dbg_tx_fifo #(
    .DEPTH    (DEPTH),
    .ACK_WAIT (ACK_WAIT)
  ) dut (
    .clk        (clk),
    .resetb     (resetb),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .tx_busy    (tx_busy),
    .tx_send    (tx_send),
    .tx_data    (tx_data),
    .level      (level),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf),
    .drop_count (drop_count),
    .sent_count (sent_count)
  );

  // 100 MHz-style bench clock; the period value does not matter to the design.
  always #5 clk = ~clk;

  // Cycle index, read by directed code and monitors after the edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, actual, actual, expected, expected, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Push one byte for exactly one cycle; call at posedge+1.
  task automatic applyStimulus(input logic [7:0] data);
    wr_en   = 1'b1;
    wr_data = data;
    tick(1);
    wr_en   = 1'b0;
  endtask

  // Wait for a total number of observed strobes within a cycle budget.
  task automatic waitStrobes(input int target, input int budget, input string name);
    int left;
    left = budget;
    while (obs_data.size() < target && left > 0) begin
      tick(1);
      left--;
    end
    checkOutput(name, obs_data.size(), target);
  endtask

  function automatic int obsData(input int i);
    if (i < obs_data.size()) return int'(obs_data[i]);
    return -1;
  endfunction

  function automatic int obsCyc(input int i);
    if (i < obs_cyc.size()) return obs_cyc[i];
    return -1;
  endfunction

  function automatic void modelReset();
    mq.delete();
    m_idle  = 1'b1;
    m_t     = 0;
    m_acked = 1'b0;
    m_txd   = 8'h00;
    m_ovf   = 1'b0;
    m_drop  = 0;
    m_sent  = 0;
  endfunction

  // One clock of the reference behaviour. Transmitter timing is described
  // as t = cycles since the pop: t=1 is the strobe, ACK lasts from t=2 until
  // busy is seen or t=ACK_WAIT+1, then wait for busy to fall.
  function automatic void modelStep();
    bit is_full;
    bit push_ok;
    bit dropped;
    bit pop_now;
    is_full = (mq.size() == DEPTH);
    push_ok = wr_en && !is_full;
    dropped = wr_en && is_full;
    pop_now = m_idle && (mq.size() != 0) && !tx_busy;

    if (!m_idle && m_t == 1) m_sent = (m_sent + 1) % 65536;

    if (m_idle) begin
      if (pop_now) begin
        m_idle  = 1'b0;
        m_t     = 1;
        m_acked = 1'b0;
        m_txd   = mq.pop_front();
      end
    end else if (m_t == 1) begin
      m_t = 2;
    end else if (!m_acked) begin
      if (tx_busy || m_t == ACK_WAIT + 1) m_acked = 1'b1;
      m_t++;
    end else if (!tx_busy) begin
      m_idle = 1'b1;
    end

    if (push_ok) mq.push_back(wr_data);

    if (dropped) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end else if (clr_ovf) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
  endfunction

  // The model follows the async reset immediately, like the DUT.
  always @(negedge resetb) modelReset();

  // Advance the model on each active edge using the inputs held that cycle.
  always @(posedge clk) begin
    if (resetb) modelStep();
  end

  // Compare every output against the model mid-cycle, and log strobes.
  always @(negedge clk) begin
    checkOutput("tx_send", int'(tx_send), int'(!m_idle && m_t == 1));
    checkOutput("tx_data", int'(tx_data), int'(m_txd));
    checkOutput("level", int'(level), mq.size());
    checkOutput("full", int'(full), int'(mq.size() == DEPTH));
    checkOutput("empty", int'(empty), int'(mq.size() == 0));
    checkOutput("overflow", int'(overflow), int'(m_ovf));
`ifdef UART_DBG_FIFO_STATS_EN
    checkOutput("drop_count", int'(drop_count), m_drop);
    checkOutput("sent_count", int'(sent_count), m_sent);
`else
    checkOutput("drop_count", int'(drop_count), 0);
    checkOutput("sent_count", int'(sent_count), 0);
`endif
    if (tx_send) begin
      obs_data.push_back(tx_data);
      obs_cyc.push_back(cyc);
    end
    if (int'(level) > peak) peak = int'(level);
  end

  // UART model driving tx_busy a little after each edge.
  initial begin
    int bcnt;
    bit last_send;
    bcnt      = 0;
    last_send = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (uart_mode)
        0: begin tx_busy = 1'b0; bcnt = 0; end
        1: begin tx_busy = 1'b1; bcnt = 0; end
        default: begin
          if (last_send) bcnt = 2900;
          if (bcnt > 0) begin
            tx_busy = 1'b1;
            bcnt--;
          end else begin
            tx_busy = 1'b0;
          end
        end
      endcase
      last_send = tx_send;
    end
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog: got no completion by 2000000 ns, expected the sequence to finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    int base;
    int n0;
    logic [7:0] exp_burst[4];
    exp_burst[0] = 8'h44;
    exp_burst[1] = 8'h42;
    exp_burst[2] = 8'h47;
    exp_burst[3] = 8'h3A;

    // Reset values
    #1 resetb = 1'b0;
    tick(3);
    checkOutput("rst_level", int'(level), 0);
    checkOutput("rst_empty", int'(empty), 1);
    checkOutput("rst_full", int'(full), 0);
    checkOutput("rst_tx_send", int'(tx_send), 0);
    checkOutput("rst_tx_data", int'(tx_data), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    resetb = 1'b1;
    tick(2);

    // Basic send: strobe two cycles after the push, then no repeat under busy
    $display("[TB] basic send");
    uart_mode = 0;
    tick(1);
    n0   = obs_data.size();
    base = cyc;
    applyStimulus(8'h44);
    waitStrobes(n0 + 1, 10, "basic_strobe_count");
    checkOutput("basic_latency", obsCyc(n0) - base, 2);
    checkOutput("basic_data", obsData(n0), 8'h44);
    checkOutput("basic_level", int'(level), 0);
    uart_mode = 1;
    tick(100);
    checkOutput("basic_no_repeat", obs_data.size(), n0 + 1);
    uart_mode = 0;
    tick(3);

    // Burst: four bytes queue while busy, then replay with a slow UART
    $display("[TB] burst order");
    uart_mode = 1;
    tick(2);
    peak = 0;
    n0   = obs_data.size();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(exp_burst[i]);
      if (i < 3) tick(15);
    end
    uart_mode = 2;
    waitStrobes(n0 + 4, 14000, "burst_strobe_count");
    for (int i = 0; i < 4; i++) checkOutput("burst_order", obsData(n0 + i), int'(exp_burst[i]));
    checkOutput("burst_peak", peak, 4);
    tick(2910);
    checkOutput("burst_empty", int'(empty), 1);
    checkOutput("burst_level", int'(level), 0);
    uart_mode = 0;
    tick(2);

    // Overflow: 34 pushes into a 32-deep FIFO while the UART is busy
    $display("[TB] overflow");
    uart_mode = 1;
    tick(2);
    n0 = obs_data.size();
    for (int i = 0; i < 32; i++) applyStimulus(8'(8'h80 + i));
    checkOutput("ovf_full_at_32", int'(full), 1);
    checkOutput("ovf_level_32", int'(level), 32);
    checkOutput("ovf_not_yet", int'(overflow), 0);
    applyStimulus(8'hE1);
    applyStimulus(8'hE2);
    checkOutput("ovf_set", int'(overflow), 1);
    checkOutput("ovf_level_kept", int'(level), 32);
`ifdef UART_DBG_FIFO_STATS_EN
    checkOutput("ovf_drop_count", int'(drop_count), 2);
`endif
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    checkOutput("ovf_cleared", int'(overflow), 0);

    // Full FIFO pops while a push arrives: the push is still dropped
    uart_mode = 0;
    wr_en     = 1'b1;
    wr_data   = 8'hEE;
    tick(1);
    wr_en     = 1'b0;
    checkOutput("fullpop_level", int'(level), 31);
    checkOutput("fullpop_overflow", int'(overflow), 1);
    checkOutput("fullpop_full", int'(full), 0);
`ifdef UART_DBG_FIFO_STATS_EN
    checkOutput("fullpop_drop_count", int'(drop_count), 1);
`endif

    // Ack timeout: busy stuck low, strobes every SEND+ACK_WAIT+DRAIN+IDLE
    $display("[TB] ack timeout drain");
    waitStrobes(n0 + 32, 32 * (ACK_WAIT + 3) + 50, "drain_strobe_count");
    for (int k = 0; k < 32; k++) checkOutput("drain_order", obsData(n0 + k), 8'h80 + k);
    for (int k = 0; k < 31; k++)
      checkOutput("timeout_spacing", obsCyc(n0 + k + 1) - obsCyc(n0 + k), ACK_WAIT + 3);
    tick(ACK_WAIT + 10);
    checkOutput("drain_no_dropped_sent", obs_data.size(), n0 + 32);
    checkOutput("drain_empty", int'(empty), 1);
`ifdef UART_DBG_FIFO_STATS_EN
    checkOutput("sent_total", int'(sent_count), 37);
`endif

    // Async reset in the middle of ACK with five bytes still queued
    $display("[TB] async reset");
    uart_mode = 0;
    for (int i = 0; i < 6; i++) applyStimulus(8'(8'h10 + i));
    tick(15);
    checkOutput("prerst_level", int'(level), 5);
    #2 resetb = 1'b0;
    #1;
    checkOutput("arst_level", int'(level), 0);
    checkOutput("arst_empty", int'(empty), 1);
    checkOutput("arst_tx_send", int'(tx_send), 0);
    checkOutput("arst_tx_data", int'(tx_data), 0);
    checkOutput("arst_overflow", int'(overflow), 0);
    checkOutput("arst_sent_count", int'(sent_count), 0);
    @(posedge clk);
    @(posedge clk);
    #1 resetb = 1'b1;
    n0 = obs_data.size();
    tick(100);
    checkOutput("arst_no_strobe", obs_data.size(), n0);
    base = cyc;
    applyStimulus(8'h5A);
    waitStrobes(n0 + 1, 10, "arst_new_strobe_count");
    checkOutput("arst_new_latency", obsCyc(n0) - base, 2);
    checkOutput("arst_new_data", obsData(n0), 8'h5A);
    tick(ACK_WAIT + 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_dbg_tx_fifo.md
Name: uart_dbg_tx_fifo

Overview:
- Elastic byte buffer between the button-triggered debug sequence generator and the UART debug transmit input (debug_send/debug_data).
- The generator emits a byte every 16 clk cycles, which is far faster than the UART can serialize. This block absorbs the burst and replays the bytes one at a time, paced by the UART's busy indication.
- It sits in the top level at 27 MHz on clk, on the same clock and reset as the UART interface.

Parameters:
- DEPTH, 32: FIFO entries. Must be a power of 2 and ≥2.
- ACK_WAIT, 64: max cycles to wait for tx_busy to rise after a tx_send pulse.
- AW, $clog2(DEPTH): pointer width (derived, not overridable).

Ports:
- clk  in  1  system clock
- resetb  in  1  asynchronous active-low reset
- wr_en  in  1  one-cycle push strobe from the debug generator
- wr_data  in  8  byte to push, sampled when wr_en=1
- tx_busy  in  1  UART transmitter busy (high while a byte is shifting out)
- tx_send  out  1  one-cycle send strobe to the UART
- tx_data  out  8  byte to send; stable from the tx_send cycle until the byte is retired
- level  out  AW+1  current occupancy, 0..DEPTH
- full  out  1  level==DEPTH
- empty  out  1  level==0
- overflow  out  1  sticky: a push was dropped
- clr_ovf  in  1  synchronous clear of overflow
- drop_count  out  8  dropped-byte counter (see Optional Feature)
- sent_count  out  16  bytes-sent counter (see Optional Feature)

Behaviour:
- Reset (async assert, sync-safe release): rd_ptr=wr_ptr=0, level=0, empty=1, full=0, overflow=0, tx_send=0, tx_data=0x00, state=IDLE, counters=0. Reset mid-transfer abandons the byte; no tx_send is issued afterwards until new data is pushed.
- Storage: register array DEPTH×8. Pointers wrap modulo DEPTH. level is a separate AW+1 counter.
- Push: wr_en=1 and full=0 → store at wr_ptr, wr_ptr+1, level+1 next cycle.
- Push with full=1 → byte dropped and overflow set next cycle. This applies even if a pop occurs in the same cycle (full is evaluated on the registered level).
- Push and pop in the same cycle → level unchanged, both pointers advance.
- overflow clear: clr_ovf=1 clears it. If a drop and clr_ovf coincide, set wins.
- TX FSM states: IDLE, SEND, ACK, DRAIN.
  - IDLE: if empty=0 and tx_busy=0 → pop (tx_data<=mem[rd_ptr], rd_ptr+1, level−1) and go to SEND.
  - SEND: tx_send=1 for exactly this cycle, then go to ACK.
  - ACK: tx_busy=1 → DRAIN. If ACK_WAIT cycles elapse without busy (counted from ACK entry), go to DRAIN anyway. This prevents a lockup if the UART misses the strobe.
  - DRAIN: tx_busy=0 → IDLE.
- Latency: push at cycle N, with the FSM in IDLE and the UART idle → level=1 at N+1, pop at N+1, tx_send high at N+2.
- Minimum spacing between consecutive tx_send pulses is 4 cycles even if tx_busy never rises before the timeout path (SEND, ACK≥1, DRAIN≥1, IDLE).
- tx_data holds its value until the next pop and is never changed while in SEND/ACK/DRAIN.
- full, empty and level are registered outputs derived from the level counter.

Optional Feature:
- Macro: UART_DBG_FIFO_STATS_EN.
- Defined:
  - drop_count increments on each dropped push and saturates at 255; cleared by clr_ovf unless a drop coincides.
  - sent_count increments on each SEND cycle and wraps at 65535→0.
- Undefined: drop_count and sent_count are tied to 0 and no counter flops are synthesized.

Test Plan:
- Basic send: push 0x44 with tx_busy=0 → tx_send pulse 2 cycles later with tx_data=0x44; level back to 0; then hold busy high 100 cycles → no second pulse.
- Burst/order: push 'D','B','G',':' every 16 cycles; UART model asserts busy 1 cycle after each strobe for 2900 cycles → four strobes in order 0x44,0x42,0x47,0x3A; peak level 4; empty=1 at end.
- Overflow: DEPTH=32, busy held high, push 34 bytes → full=1 after 32; overflow=1; drop_count=2 (with macro); bytes 33–34 never sent. Assert clr_ovf → overflow=0.
- Full + pop same cycle: full FIFO, FSM pops while a push arrives → push dropped, level=31, overflow=1.
- Ack timeout: tx_busy stuck 0 → after each strobe, ACK exits after 64 cycles; all queued bytes still sent in order; sent_count equals push count.
- Async reset: assert resetb=0 mid-ACK with 5 bytes queued → outputs take reset values immediately; after release, no tx_send until a new push; that push is the next byte sent.
